spi_frame_receiver: RTL
=======================

# spi_frame_receiver

SPI slave front end of the I/O expander. It oversamples the SPI pins with the system clock and deserialises 16-bit mode-0 frames into a 4-bit port address, a read/write command and an 8-bit data byte. It drives the address decoder's `addrBus`/`addrSel` inputs and the port write path, and shifts read-back data out on MISO.

## Interface
- `SYNC_STAGES`, default 2: flip-flop depth of the synchronisers on `sclk`, `csN` and `mosi`. Minimum 2.
- `clk` in 1: system clock. Must run at ≥ 8× the SCLK frequency.
- `rst` in 1: reset, synchronous, active-high.
- `sclk` in 1: SPI clock, asynchronous, idles low (mode 0).
- `csN` in 1: SPI chip select, asynchronous, active-low.
- `mosi` in 1: SPI data in, asynchronous.
- `miso` out 1: SPI data out.
- `addrBus` out 4: port address taken from the command byte; feeds the decoder.
- `addrSel` out 1: one-cycle select strobe to the decoder.
- `wrEn` out 1: one-cycle write strobe, coincident with `addrSel` on writes.
- `dataOut` out 8: write data, valid while `wrEn` is high and held until the next write.
- `readData` in 8: data from the addressed port; sampled on reads.
- `frameErr` out 1: one-cycle pulse when a frame is aborted.
- `busy` out 1: high while a frame is in progress.

## Operation
- Frame layout, MSB first: byte0 = {rw, 3 ignored bits, addr[3:0]}, with rw=1 meaning write. byte1 = write data (MOSI) or read data (MISO).
- Synchronisers: `csN` resets to 1; `sclk` and `mosi` reset to 0. Edge detection runs on the final synchroniser stage.
- FSM states:
  - IDLE → CMD when the synchronised `csN` shows a falling edge. On entry, `bitCnt` is cleared.
  - CMD: each rising `sclk` edge shifts in `mosi` and increments `bitCnt`. At `bitCnt`=8, latch `addrBus` and `rw`, then go to DATA. If rw=0, pulse `addrSel` for one cycle; `readData` is sampled into the TX register the following cycle.
  - DATA: each rising edge shifts in `mosi`. At `bitCnt`=16 go to DONE. If rw=1, load `dataOut` and pulse `wrEn`+`addrSel` for one cycle.
  - DONE: further `sclk` edges are ignored. Return to IDLE when `csN` rises.
- Abort: if `csN` rises in CMD or DATA, return to IDLE and pulse `frameErr`. No write strobe is issued. A read `addrSel` already issued is not retracted.
- MISO behaviour:
  - Outside a read data phase, `miso` = 0.
  - When the TX register loads, `miso` = `readData[7]`.
  - The register shifts on each falling `sclk` edge while `bitCnt` is 9–15. The falling edge at `bitCnt`=8 does not shift.
  - `miso` returns to 0 on entry to DONE or IDLE.
- `busy` is 1 in CMD, DATA and DONE.
- Reset mid-frame:
  - All state and outputs return to reset values immediately.
  - If `csN` is still low when `rst` deasserts, the partial frame is ignored. The next frame starts only at a fresh `csN` falling edge.

## Timing
- Reset values: `miso`=0, `addrBus`=0, `addrSel`=0, `wrEn`=0, `dataOut`=0, `frameErr`=0, `busy`=0; FSM in IDLE.
- Pin-to-edge-pulse latency is SYNC_STAGES+1 clk cycles. Shifts, counter updates and state changes are registered on the cycle after the edge pulse.
- Read `addrSel` is high exactly 1 cycle, starting 1 cycle after the 8th rising-edge pulse. The TX register loads 1 cycle after `addrSel`.
- Write `wrEn`/`addrSel` are high exactly 1 cycle, starting 1 cycle after the 16th rising-edge pulse. `addrBus` is stable from byte0 completion through the strobe.
- `frameErr` is a 1-cycle pulse, 1 cycle after the `csN` rising-edge pulse.
- The 8× clock ratio guarantees the TX load completes before the first falling edge after bit 8.
- Simultaneous 16th rising edge and `csN` rise cannot occur: under mode 0, CS rises only after SCLK is low.

## Test plan
- Write frame 0x85,0xA5 (addr 5) → one cycle with `addrBus`=5, `addrSel`=1, `wrEn`=1, `dataOut`=0xA5; `busy` falls after `csN` rises.
- Read frame 0x0C, `readData`=0x3C → one `addrSel` pulse with `addrBus`=12 and `wrEn`=0; master samples MISO as 0x3C.
- `csN` rises after 11 bits of a write → `frameErr` pulses once; no `wrEn`; `dataOut` keeps its previous value.
- 24-bit write frame 0x81,0x5A,0xFF → exactly one `wrEn`, with `dataOut`=0x5A; the trailing bits are ignored.
- Assert `rst` mid-frame with `csN` held low, then release and finish clocking → no strobes; a following full frame works normally.
- Sweep addr 0–15 with writes → `addrBus` equals addr on each strobe; `SYNC_STAGES`=3 build passes the same test.

Source files
------------

// File: rtl/spi_frame_receiver.sv
// SPI mode-0 slave front end: oversamples the SPI pins and turns 16-bit frames
// into a {rw, addr} command with a write-data byte or a read-back byte on MISO.
module spi_frame_receiver #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       csN,
    input  logic       mosi,
    output logic       miso,
    output logic [3:0] addrBus,
    output logic       addrSel,
    output logic       wrEn,
    output logic [7:0] dataOut,
    input  logic [7:0] readData,
    output logic       frameErr,
    output logic       busy
);

    // state | meaning
    // IDLE  | waiting for a csN falling edge
    // CMD   | shifting in the command byte
    // DATA  | shifting the data byte in (write) or out (read)
    // DONE  | frame complete, extra bits ignored until csN rises
    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q, fill_q;
    logic                   sclk_prev_q, cs_prev_q, armed_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // A frame may only start after csN has been seen high with a real pin
    // sample, so a frame cut short by reset is never picked up halfway.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            fill_q      <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            armed_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], csN};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            armed_q     <= armed_q | (fill_q[SYNC_STAGES-1] & cs_s);
        end
    end

    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign cs_fall   = armed_q & ~cs_s & cs_prev_q;

    state_t     state_q, state_d;
    logic [4:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] data_q, data_d;
    logic [3:0] addr_q, addr_d;
    logic       rw_q, rw_d;
    logic       tx_active_q, tx_active_d;
    logic       load_tx_q, load_tx_d;
    logic       addr_sel_q, addr_sel_d;
    logic       wr_en_q, wr_en_d;
    logic       frame_err_q, frame_err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            tx_q        <= '0;
            data_q      <= '0;
            addr_q      <= '0;
            rw_q        <= 1'b0;
            tx_active_q <= 1'b0;
            load_tx_q   <= 1'b0;
            addr_sel_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            data_q      <= data_d;
            addr_q      <= addr_d;
            rw_q        <= rw_d;
            tx_active_q <= tx_active_d;
            load_tx_q   <= load_tx_d;
            addr_sel_q  <= addr_sel_d;
            wr_en_q     <= wr_en_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        data_d      = data_q;
        addr_d      = addr_q;
        rw_d        = rw_q;
        tx_active_d = tx_active_q;
        load_tx_d   = 1'b0;
        addr_sel_d  = 1'b0;
        wr_en_d     = 1'b0;
        frame_err_d = 1'b0;

        // readData is sampled while the decoder still sees the read addrSel.
        if (load_tx_q) begin
            tx_d        = readData;
            tx_active_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                tx_active_d = 1'b0;
                if (cs_fall) begin
                    state_d   = CMD;
                    bit_cnt_d = '0;
                end
            end
            CMD: begin
                if (cs_rise) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end else if (sclk_rise) begin
                    shift_d   = {shift_q[6:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd7) begin
                        addr_d  = {shift_q[2:0], mosi_s};
                        rw_d    = shift_q[6];
                        state_d = DATA;
                        if (!shift_q[6]) begin
                            addr_sel_d = 1'b1;
                            load_tx_d  = 1'b1;
                        end
                    end
                end
            end
            DATA: begin
                if (cs_rise) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                    tx_active_d = 1'b0;
                end else if (sclk_rise) begin
                    shift_d   = {shift_q[6:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd15) begin
                        state_d     = DONE;
                        tx_active_d = 1'b0;
                        if (rw_q) begin
                            data_d     = {shift_q[6:0], mosi_s};
                            wr_en_d    = 1'b1;
                            addr_sel_d = 1'b1;
                        end
                    end
                end else if (sclk_fall && tx_active_q &&
                             bit_cnt_q >= 5'd9 && bit_cnt_q <= 5'd15) begin
                    tx_d = {tx_q[6:0], 1'b0};
                end
            end
            DONE: begin
                tx_active_d = 1'b0;
                if (cs_rise) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign miso     = tx_active_q & tx_q[7];
    assign addrBus  = addr_q;
    assign addrSel  = addr_sel_q;
    assign wrEn     = wr_en_q;
    assign dataOut  = data_q;
    assign frameErr = frame_err_q;
    assign busy     = (state_q != IDLE);

endmodule
